// File: rtl/adder_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined adder.
package adder_pipe_pkg;

    // Per-stage control bits; the operand/result vectors are appended by the
    // stage module because their width follows its SIZE parameter.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_ctl_t;

    function automatic int chunk_width(input int size, input int nbstages);
        return size / nbstages;
    endfunction

    function automatic bit chunks_even(input int size, input int nbstages);
        return (nbstages > 0) && ((size % nbstages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand and result streams of adder_pipe, each with its own valid/ready pair.
interface adder_pipe_if #(
    parameter int SIZE = 8
);
    logic            valid_i;
    logic            ready_o;
    logic [SIZE-1:0] a_i;
    logic [SIZE-1:0] b_i;
    logic            carryin_i;
    logic            sub_i;
    logic            valid_o;
    logic            ready_i;
    logic [SIZE-1:0] result_o;
    logic            carryout_o;
    logic            overflow_o;

    modport slave (
        input  valid_i, a_i, b_i, carryin_i, sub_i, ready_i,
        output ready_o, valid_o, result_o, carryout_o, overflow_o
    );

    modport master (
        output valid_i, a_i, b_i, carryin_i, sub_i, ready_i,
        input  ready_o, valid_o, result_o, carryout_o, overflow_o
    );
endinterface

// File: rtl/adder_pipe_stage.sv
// One CHUNK-wide slice of the carry chain plus its register; 1 cycle latency,
// holds its contents whenever advance is low.
module adder_pipe_stage
    import adder_pipe_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            prev_valid,
    input  logic            prev_carry,
    input  logic [SIZE-1:0] prev_a,
    input  logic [SIZE-1:0] prev_b,
    input  logic [SIZE-1:0] prev_res,
    output logic            valid,
    output logic            carry,
    output logic            ovf,
    output logic [SIZE-1:0] a,
    output logic [SIZE-1:0] b,
    output logic [SIZE-1:0] res
);

    typedef struct packed {
        stage_ctl_t      ctl;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [SIZE-1:0] res;
    } stage_t;

    stage_t           cur_q;
    stage_t           nxt;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_out;

    assign a_chunk = prev_a[IDX*CHUNK +: CHUNK];
    assign b_chunk = prev_b[IDX*CHUNK +: CHUNK];
    assign {c_out, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, prev_carry};

    always_comb begin
        nxt           = '0;
        nxt.ctl.valid = prev_valid;
        nxt.ctl.carry = c_out;
        // Carry into the chunk MSB is a^b^sum at that bit; only the last stage's copy is used.
        nxt.ctl.ovf   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1] ^ c_out;
        nxt.a         = prev_a;
        nxt.b         = prev_b;
        nxt.res       = prev_res;
        nxt.res[IDX*CHUNK +: CHUNK] = s_chunk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q <= '0;
        end else if (advance) begin
            cur_q <= nxt;
        end
    end

    assign valid = cur_q.ctl.valid;
    assign carry = cur_q.ctl.carry;
    assign ovf   = cur_q.ctl.ovf;
    assign a     = cur_q.a;
    assign b     = cur_q.b;
    assign res   = cur_q.res;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with carry-out and signed overflow, one register per carry chunk.
// Latency NBSTAGES cycles; the whole pipe freezes only while a result waits on ready_i.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int NBSTAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    adder_pipe_if.slave bus
);

    localparam int CHUNK = chunk_width(SIZE, NBSTAGES);

    if (!chunks_even(SIZE, NBSTAGES)) begin : g_bad_split
        $error("adder_pipe: SIZE (%0d) must be a multiple of NBSTAGES (%0d)", SIZE, NBSTAGES);
    end

    // Index 0 is the operand port; index k+1 is the register of stage k.
    logic            valid_s [NBSTAGES+1];
    logic            carry_s [NBSTAGES+1];
    logic            ovf_s   [NBSTAGES+1];
    logic [SIZE-1:0] a_s     [NBSTAGES+1];
    logic [SIZE-1:0] b_s     [NBSTAGES+1];
    logic [SIZE-1:0] res_s   [NBSTAGES+1];
    logic            advance;

    assign valid_s[0] = bus.valid_i;
    assign carry_s[0] = bus.carryin_i;
    assign ovf_s[0]   = 1'b0;
    assign a_s[0]     = bus.a_i;
    assign b_s[0]     = bus.sub_i ? ~bus.b_i : bus.b_i;
    assign res_s[0]   = '0;

    // Bubbles are not squeezed out: the pipe moves as one unit.
    assign advance = !valid_s[NBSTAGES] || bus.ready_i;

    for (genvar k = 0; k < NBSTAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .SIZE  (SIZE),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk        (clk_i),
            .rst        (rst_i),
            .advance    (advance),
            .prev_valid (valid_s[k]),
            .prev_carry (carry_s[k]),
            .prev_a     (a_s[k]),
            .prev_b     (b_s[k]),
            .prev_res   (res_s[k]),
            .valid      (valid_s[k+1]),
            .carry      (carry_s[k+1]),
            .ovf        (ovf_s[k+1]),
            .a          (a_s[k+1]),
            .b          (b_s[k+1]),
            .res        (res_s[k+1])
        );
    end

    assign bus.ready_o    = advance;
    assign bus.valid_o    = valid_s[NBSTAGES];
    assign bus.result_o   = res_s[NBSTAGES];
    assign bus.carryout_o = carry_s[NBSTAGES];
    assign bus.overflow_o = ovf_s[NBSTAGES];

endmodule
